// File: rtl/memd_pipe.sv
// Parametrised data memory with a latency-configurable tagged read pipeline,
// valid/ready request handshake, optional writes, speculative flush and flash/sweep clear.
module memd_pipe #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 2,
   parameter int DEPTH     = 4,
   parameter int LATENCY   = 1,
   parameter int WRITE_EN  = 1,
   parameter int SWEEP_CLR = 0,
   parameter int TAG_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rdwt,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              flush,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              init_done,
   output logic [7:0]        wr_drop_cnt
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {INIT, READY} state_t;

   state_t            state;
   logic [IDX_W-1:0]  sweep_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              addr_ok;
   logic              acc;
   logic              rd_fire;
   logic              wr_fire;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_word;

   logic              vld_in  [LATENCY];
   logic [DATA_W-1:0] data_in [LATENCY];
   logic [TAG_W-1:0]  tag_in  [LATENCY];
   logic              vld_p   [LATENCY];
   logic [DATA_W-1:0] data_p  [LATENCY];
   logic [TAG_W-1:0]  tag_p   [LATENCY];

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign addr_ok = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
   assign idx     = req_addr[IDX_W-1:0];
   assign acc     = req_valid && req_ready;
   assign rd_fire = acc && req_rdwt;
   assign wr_fire = acc && !req_rdwt;
   assign rd_word = addr_ok ? mem[idx] : '0;

   // Control FSM: ready/init_done are registered copies of state==READY
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         req_ready <= 1'b0;
         init_done <= 1'b0;
         sweep_cnt <= '0;
      end else begin
         case (state)
            INIT: begin
               if (SWEEP_CLR == 0 || sweep_cnt == IDX_W'(DEPTH - 1)) begin
                  state     <= READY;
                  req_ready <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  sweep_cnt <= sweep_cnt + 1'b1;
               end
            end
            READY: begin
               state <= READY;
            end
            default: begin
               state     <= INIT;
               req_ready <= 1'b0;
               init_done <= 1'b0;
            end
         endcase
      end
   end

   // Array: clear (flash during rst, or one word per INIT cycle), then committed writes
   always_ff @(posedge clk) begin
      if (rst) begin
         if (SWEEP_CLR == 0) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         end
      end else if (state == INIT) begin
         if (SWEEP_CLR != 0) mem[sweep_cnt] <= '0;
      end else if (wr_fire && addr_ok && (WRITE_EN != 0)) begin
         mem[idx] <= req_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_drop_cnt <= 8'd0;
      end else if ((WRITE_EN == 0) && wr_fire && addr_ok) begin
         wr_drop_cnt <= sat_inc8(wr_drop_cnt);
      end
   end

   always_comb begin
      vld_in[0]  = rd_fire;
      data_in[0] = rd_word;
      tag_in[0]  = req_tag;
      for (int i = 1; i < LATENCY; i++) begin
         vld_in[i]  = vld_p[i-1];
         data_in[i] = data_p[i-1];
         tag_in[i]  = tag_p[i-1];
      end
   end

   // Stage p0..p(LATENCY-1): valid bits are squashed on flush, including a same-edge read
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
      end else begin
         for (int i = 0; i < LATENCY; i++) vld_p[i] <= vld_in[i];
      end
   end

   // Last stage is the output register: it holds its value between responses
   always_ff @(posedge clk) begin
      for (int i = 0; i < LATENCY; i++) begin
         if (i == LATENCY - 1) begin
            if (rst) begin
               data_p[i] <= '0;
               tag_p[i]  <= '0;
            end else if (vld_in[i] && !flush) begin
               data_p[i] <= data_in[i];
               tag_p[i]  <= tag_in[i];
            end
         end else begin
            data_p[i] <= data_in[i];
            tag_p[i]  <= tag_in[i];
         end
      end
   end

   assign resp_valid = vld_p[LATENCY-1];
   assign resp_data  = data_p[LATENCY-1];
   assign resp_tag   = tag_p[LATENCY-1];

endmodule

// File: tb/tb_memd_pipe.sv
// Scoreboard bench for memd_pipe: four instances cover LATENCY 1/2/3, read-only mode and sweep clear.
module tb_memd_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst        [4];
   logic       req_valid  [4];
   logic       req_ready  [4];
   logic       req_rdwt   [4];
   logic [1:0] req_addr   [4];
   logic [7:0] req_data   [4];
   logic [3:0] req_tag    [4];
   logic       flush      [4];
   logic       resp_valid [4];
   logic [7:0] resp_data  [4];
   logic [3:0] resp_tag   [4];
   logic       init_done  [4];
   logic [7:0] wr_drop_cnt[4];

   // inst0: LAT1 read-only, inst1: LAT3, inst2: LAT2, inst3: LAT1 sweep clear
   for (genvar g = 0; g < 4; g++) begin : g_dut
      memd_pipe #(
         .DATA_W(8), .ADDR_W(2), .DEPTH(4),
         .LATENCY(g == 1 ? 3 : (g == 2 ? 2 : 1)),
         .WRITE_EN(g == 0 ? 0 : 1),
         .SWEEP_CLR(g == 3 ? 1 : 0),
         .TAG_W(4)
      ) u_dut (
         .clk(clk), .rst(rst[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_rdwt(req_rdwt[g]), .req_addr(req_addr[g]), .req_data(req_data[g]),
         .req_tag(req_tag[g]), .flush(flush[g]), .resp_valid(resp_valid[g]),
         .resp_data(resp_data[g]), .resp_tag(resp_tag[g]), .init_done(init_done[g]),
         .wr_drop_cnt(wr_drop_cnt[g])
      );
   end

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic [3:0] tag;
      int         due;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   resp_cnt [4] = '{0, 0, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         if (resp_valid[k] === 1'b1) begin
            resp_cnt[k]++;
            n_tests++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_resp: inst=%0d got data=%02h tag=%0h at cyc %0d, required no response",
                        k, resp_data[k], resp_tag[k], cyc);
            end else begin
               e = sbq.pop_front();
               if (e.inst != k || e.data !== resp_data[k] || e.tag !== resp_tag[k] || e.due != cyc) begin
                  n_fail++;
                  $display("FAIL resp_check: got inst=%0d data=%02h tag=%0h cyc=%0d, required inst=%0d data=%02h tag=%0h cyc=%0d",
                           k, resp_data[k], resp_tag[k], cyc, e.inst, e.data, e.tag, e.due);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int k, input int n);
      rst[k] = 1'b1;
      repeat (n) tick();
      rst[k] = 1'b0;
   endtask

   task automatic issue(input int k, input logic rd, input logic [1:0] a, input logic [7:0] d,
                        input logic [3:0] t, input logic fl, input logic expect_resp,
                        input logic [7:0] ed, input int lat);
      chk("ready_at_issue", 32'(req_ready[k]), 1);
      req_valid[k] = 1'b1;
      req_rdwt[k]  = rd;
      req_addr[k]  = a;
      req_data[k]  = d;
      req_tag[k]   = t;
      flush[k]     = fl;
      tick();
      if (rd && expect_resp) sbq.push_back('{k, ed, t, cyc + lat - 1});
      req_valid[k] = 1'b0;
      flush[k]     = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_done", sbq.size(), 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      for (int k = 0; k < 4; k++) begin
         rst[k] = 1'b1; req_valid[k] = 1'b0; req_rdwt[k] = 1'b0; req_addr[k] = 2'd0;
         req_data[k] = 8'd0; req_tag[k] = 4'd0; flush[k] = 1'b0;
      end
      repeat (2) tick();

      // Test 1: reset values, ready after E0, read addr 3 tag 5 -> 0
      do_reset(0, 2);
      chk("t1_rst_req_ready", 32'(req_ready[0]), 0);
      chk("t1_rst_init_done", 32'(init_done[0]), 0);
      chk("t1_rst_resp_valid", 32'(resp_valid[0]), 0);
      chk("t1_rst_resp_data", 32'(resp_data[0]), 0);
      chk("t1_rst_resp_tag", 32'(resp_tag[0]), 0);
      chk("t1_rst_wr_drop", 32'(wr_drop_cnt[0]), 0);
      tick();
      chk("t1_ready_after_e0", 32'(req_ready[0]), 1);
      chk("t1_init_done_after_e0", 32'(init_done[0]), 1);
      issue(0, 1'b1, 2'd3, 8'h00, 4'd5, 1'b0, 1'b1, 8'h00, 1);
      drain();

      // Test 5: read-only mode, drop count saturates at 255
      for (int i = 0; i < 254; i++) issue(0, 1'b0, 2'd1, 8'(i), 4'd0, 1'b0, 1'b0, 8'h00, 1);
      chk("t5_drop_254", 32'(wr_drop_cnt[0]), 254);
      for (int i = 0; i < 46; i++) issue(0, 1'b0, 2'd1, 8'hAB, 4'd0, 1'b0, 1'b0, 8'h00, 1);
      chk("t5_drop_sat_255", 32'(wr_drop_cnt[0]), 255);
      issue(0, 1'b1, 2'd1, 8'h00, 4'd2, 1'b0, 1'b1, 8'h00, 1);
      drain();
      chk("t5_resp_data_held", 32'(resp_data[0]), 0);
      do_reset(0, 1);
      chk("t5_rst_drop_cleared", 32'(wr_drop_cnt[0]), 0);

      // Test 2: LAT3 write 0xA5 to addr 2, read it next cycle
      do_reset(1, 2);
      tick();
      issue(1, 1'b0, 2'd2, 8'hA5, 4'd0, 1'b0, 1'b0, 8'h00, 3);
      issue(1, 1'b1, 2'd2, 8'h00, 4'd7, 1'b0, 1'b1, 8'hA5, 3);
      drain();
      chk("t2_resp_data_hold", 32'(resp_data[1]), 32'h A5);
      chk("t2_resp_tag_hold", 32'(resp_tag[1]), 7);

      // Test 4: LAT3 flush squashes three reads, a write on the flush edge commits
      base = resp_cnt[1];
      issue(1, 1'b1, 2'd0, 8'h00, 4'd1, 1'b0, 1'b0, 8'h00, 3);
      issue(1, 1'b1, 2'd1, 8'h00, 4'd2, 1'b0, 1'b0, 8'h00, 3);
      issue(1, 1'b1, 2'd2, 8'h00, 4'd3, 1'b1, 1'b0, 8'h00, 3);
      issue(1, 1'b1, 2'd2, 8'h00, 4'd9, 1'b0, 1'b1, 8'hA5, 3);
      drain();
      repeat (3) tick();
      chk("t4_resp_count", resp_cnt[1] - base, 1);
      issue(1, 1'b0, 2'd3, 8'h3C, 4'd0, 1'b1, 1'b0, 8'h00, 3);
      issue(1, 1'b1, 2'd3, 8'h00, 4'd4, 1'b0, 1'b1, 8'h3C, 3);
      drain();

      // Test 3: LAT2 back-to-back reads after preload
      do_reset(2, 2);
      tick();
      for (int i = 0; i < 4; i++) issue(2, 1'b0, 2'(i), 8'h10 + 8'(i), 4'd0, 1'b0, 1'b0, 8'h00, 2);
      for (int i = 0; i < 4; i++) issue(2, 1'b1, 2'(i), 8'h00, 4'(i + 1), 1'b0, 1'b1, 8'h10 + 8'(i), 2);
      drain();

      // Test 6: sweep clear, ready only from the 5th rst=0 cycle, reset restarts sweep
      do_reset(3, 2);
      chk("t6_ready_cyc1", 32'(req_ready[3]), 0);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk("t6_ready_during_sweep", 32'(req_ready[3]), 0);
      end
      tick();
      chk("t6_ready_cyc5", 32'(req_ready[3]), 1);
      chk("t6_init_done_cyc5", 32'(init_done[3]), 1);
      issue(3, 1'b0, 2'd1, 8'h77, 4'd0, 1'b0, 1'b0, 8'h00, 1);
      issue(3, 1'b1, 2'd1, 8'h00, 4'd6, 1'b0, 1'b1, 8'h77, 1);
      drain();
      issue(3, 1'b0, 2'd1, 8'h77, 4'd0, 1'b0, 1'b0, 8'h00, 1);
      do_reset(3, 1);
      n = 0;
      while (req_ready[3] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("t6_resweep_cycles", n, 4);
      issue(3, 1'b1, 2'd1, 8'h00, 4'd8, 1'b0, 1'b1, 8'h00, 1);
      drain();

      chk("sb_empty_at_end", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/memd_pipe.md
# memd_pipe

Parametrised data memory for the simple out-of-order core, the successor to the single-cycle, read-only data memory. It adds configurable read latency, a valid/ready request handshake, optional writes, tagged responses, a speculative-squash flush, and a choice between flash clear and sweep clear at reset. It sits between the core's load/store issue logic and its writeback/commit path.

## Interface
- DATA_W, 8: word width in bits.
- ADDR_W, 2: address width in bits.
- DEPTH, 4: number of words, where 1 ≤ DEPTH ≤ 2^ADDR_W.
- LATENCY, 1: read latency in cycles, range 1..4.
- WRITE_EN, 1: 1 means writes commit; 0 means writes are accepted and dropped (read-only mode).
- SWEEP_CLR, 0: 0 means the array is flash-cleared during rst; 1 means it is cleared one word per cycle after rst.
- TAG_W, 4: width of the request/response tag.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_rdwt  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  word address.
- req_data  in  DATA_W  write data.
- req_tag  in  TAG_W  returned with the read response.
- flush  in  1  squash all in-flight reads.
- resp_valid  out  1  read response valid.
- resp_data  out  DATA_W  read data.
- resp_tag  out  TAG_W  tag of the responding read.
- init_done  out  1  array clear has finished.
- wr_drop_cnt  out  8  saturating count of dropped writes.

## Operation
- Accept: a request fires on an edge where req_valid && req_ready. At most one request per cycle.
- FSM states:
  - INIT:
    - Entered from any state when rst=1.
    - SWEEP_CLR=0: the array is zeroed on every edge with rst=1. On the first edge with rst=0, go to READY.
    - SWEEP_CLR=1: a sweep counter is cleared while rst=1. On each subsequent edge, write 0 to array[cnt] and increment cnt. After writing word DEPTH-1, go to READY.
  - READY: normal operation. Stays in READY until rst.
- req_ready = (state==READY). init_done = (state==READY).
- Read:
  - Data comes from array[req_addr] sampled at the accept edge.
  - Data, tag and a valid bit enter a LATENCY-deep shift pipeline.
  - req_addr ≥ DEPTH returns 0.
- Write:
  - WRITE_EN=1: array[req_addr] ← req_data at the accept edge.
  - WRITE_EN=0: array unchanged; wr_drop_cnt increments, saturating at 255.
  - req_addr ≥ DEPTH: ignored and not counted.
  - Writes produce no response.
- Ordering:
  - A read accepted at any edge after a write's accept edge sees the written value.
  - Only one request is accepted per edge, so same-edge read/write conflicts cannot occur.
- Flush:
  - On an edge with flush=1, every pipeline valid bit is cleared.
  - A read accepted on that same edge is also squashed; a write accepted on that edge still commits.
  - The response already presented during the flush cycle counts as delivered.
- Reset mid-operation: all in-flight reads are lost, the array is cleared again, wr_drop_cnt returns to 0, and any sweep restarts from word 0.

## Timing
- Reset values, in the cycle after a rst edge: req_ready=0, init_done=0, resp_valid=0, resp_data=0, resp_tag=0, wr_drop_cnt=0.
- After rst deasserts (edge E0 is the first edge with rst=0):
  - SWEEP_CLR=0: req_ready=1 in the cycle after E0.
  - SWEEP_CLR=1: req_ready=1 after DEPTH edges starting at E0, i.e. from cycle DEPTH+1 counting the first rst=0 cycle as cycle 1.
- Read accepted at edge N: resp_valid=1 for exactly one cycle, in the cycle following edge N+LATENCY-1. With LATENCY=1 this is the cycle right after acceptance.
- Throughput: one read per cycle. Responses return in acceptance order with no gaps beyond request gaps.
- resp_data and resp_tag hold their last values when resp_valid=0.
- Outputs are registered. req_ready depends only on state, with no combinational path from req_valid.

## Test plan
1. Reset, SWEEP_CLR=0, LATENCY=1: rst for 2 cycles, then read addr 3 with tag 5.
   - Required: req_ready=1 in the first rst=0 cycle's successor.
   - Required: resp_valid=1 one cycle after accept, with data 0 and tag 5.
2. Write-then-read, WRITE_EN=1, LATENCY=3: write 0xA5 to addr 2, read addr 2 on the next cycle.
   - Required: resp_data=0xA5, resp_valid exactly 3 cycles after the read accept.
3. Back-to-back reads with LATENCY=2: reads of addr 0,1,2,3 on consecutive cycles with tags 1..4, after preloading 0x10..0x13.
   - Required: 4 consecutive resp_valid cycles carrying data 0x10..0x13 and tags 1..4, in order.
4. Flush, LATENCY=3: issue reads on cycles 0,1,2; assert flush on cycle 2.
   - Required: no response for any of the three reads.
   - Required: a read issued on cycle 3 responds normally.
5. WRITE_EN=0: 300 writes to addr 1, then read addr 1.
   - Required: resp_data=0 and wr_drop_cnt=255.
6. SWEEP_CLR=1, DEPTH=4:
   - Required: req_ready stays 0 for 4 cycles after rst deasserts.
   - Then: write 0x77 and assert rst mid-stream; after the new sweep completes, a read of that address returns 0.
